// File: rtl/corescore_stream_pkg.sv
// Shared types and constants for the corescore byte-stream FIFO.
// Each stored entry is one byte of message data plus its end-of-packet flag.
package corescore_stream_pkg;

   localparam int BYTE_W        = 8;
   localparam int ENTRY_W       = 9;
   localparam int DEFAULT_DEPTH = 64;

   typedef struct packed {
      logic              last;
      logic [BYTE_W-1:0] data;
   } entry_t;

endpackage

// File: rtl/corescore_stream_fifo_ram.sv
// Simple dual-port storage: one write port, one synchronous read port with enable.
// The read register doubles as the FIFO output stage, so it only updates when re is high.
module corescore_stream_fifo_ram
   import corescore_stream_pkg::*;
#(
   parameter  int DEPTH = DEFAULT_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  entry_t        wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output entry_t        rdata
);

   entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/corescore_stream_fifo.sv
// Elastic byte FIFO between the corescore message stream and the UART emitter.
// Optional whole-packet release is enabled by defining CORESCORE_STREAM_FIFO_PKT_MODE_EN.
module corescore_stream_fifo
   import corescore_stream_pkg::*;
#(
   parameter  int DEPTH = DEFAULT_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [BYTE_W-1:0] i_tdata,
   input  logic              i_tlast,
   input  logic              i_tvalid,
   output logic              o_tready,
   output logic [BYTE_W-1:0] o_tdata,
   output logic              o_tlast,
   output logic              o_tvalid,
   input  logic              i_tready,
   output logic [AW:0]       o_level
);

   // Handshake: a byte moves on a rising edge where valid && ready are both high;
   // a raised valid holds its data until that transfer and never depends on ready.
   localparam logic [AW:0] FULL_XOR = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] ONE      = {{AW{1'b0}}, 1'b1};

   logic [AW:0] wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx, level, load_ptr;
   logic        tready_q, tvalid_q;
   logic        do_wr, do_rd, do_load, stored_ahead, release_ok;
   entry_t      wr_entry, rd_entry;

   // rd_ptr addresses the entry held in the output register, so the next fetch is one beyond it.
   assign level        = wr_ptr - rd_ptr;
   assign do_wr        = i_rst_n && i_tvalid && tready_q;
   assign do_rd        = tvalid_q && i_tready;
   assign stored_ahead = level > {{AW{1'b0}}, tvalid_q};
   assign load_ptr     = rd_ptr + {{AW{1'b0}}, tvalid_q};
   assign do_load      = i_rst_n && (!tvalid_q || i_tready) && stored_ahead && release_ok;
   assign wr_ptr_nx    = do_wr ? wr_ptr + ONE : wr_ptr;
   assign rd_ptr_nx    = do_rd ? rd_ptr + ONE : rd_ptr;
   assign wr_entry     = '{last: i_tlast, data: i_tdata};

`ifdef CORESCORE_STREAM_FIFO_PKT_MODE_EN
   logic [AW:0] pkt_cnt, complete_ahead;
   logic        full, draining, in_packet;

   // A full buffer with no complete packet is an oversize message: release it to avoid deadlock.
   assign full           = (wr_ptr ^ rd_ptr) == FULL_XOR;
   assign in_packet      = tvalid_q ? !rd_entry.last : draining;
   assign complete_ahead = pkt_cnt - {{AW{1'b0}}, tvalid_q && rd_entry.last};
   assign release_ok     = in_packet || full || (complete_ahead != '0);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         pkt_cnt  <= '0;
         draining <= 1'b0;
      end else begin
         case ({do_wr && i_tlast, do_rd && rd_entry.last})
            2'b10:   pkt_cnt <= pkt_cnt + ONE;
            2'b01:   pkt_cnt <= pkt_cnt - ONE;
            default: pkt_cnt <= pkt_cnt;
         endcase
         if (do_rd) draining <= !rd_entry.last;
      end
   end
`else
   assign release_ok = 1'b1;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         tvalid_q <= 1'b0;
         tready_q <= 1'b0;
      end else begin
         wr_ptr   <= wr_ptr_nx;
         rd_ptr   <= rd_ptr_nx;
         tready_q <= (wr_ptr_nx ^ rd_ptr_nx) != FULL_XOR;
         if (do_load)    tvalid_q <= 1'b1;
         else if (do_rd) tvalid_q <= 1'b0;
      end
   end

   corescore_stream_fifo_ram #(.DEPTH(DEPTH)) u_ram (
      .clk   (i_clk),
      .we    (do_wr),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (wr_entry),
      .re    (do_load),
      .raddr (load_ptr[AW-1:0]),
      .rdata (rd_entry)
   );

   assign o_tready = tready_q;
   assign o_tvalid = tvalid_q;
   assign o_tdata  = rd_entry.data;
   assign o_tlast  = rd_entry.last;
   assign o_level  = level;

endmodule
